// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use and multiply scoreboard stalls,
// multiplier structural stall, control-hazard flushes and a saturating stall counter.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned NRD     = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] RAD,
  input  logic [NRD-1:0]    RVD,
  input  logic [NRD*AW-1:0] RAE,
  input  logic [AW-1:0]     WA3E,
  input  logic [AW-1:0]     WA3M,
  input  logic [AW-1:0]     WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MulD,
  input  logic              MulIssueE,
  input  logic              MulDone,
  input  logic [AW-1:0]     MulWA,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              StallClr,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [2*NRD-1:0]  ForwardE,
  output logic              MulBusy,
  output logic [15:0]       StallCount
);

  localparam int unsigned CW  = 4;
  localparam int unsigned SCW = 16;

  logic [NREG-1:0] r_pend;
  logic [CW-1:0]   r_busy_cnt;
  logic [SCW-1:0]  r_stall_cnt;

  logic [NREG-1:0]  w_pend_eff;
  logic [2*NRD-1:0] w_fwd;
  logic             w_ldr_stall;
  logic             w_pend_stall;
  logic             w_struct_stall;
  logic             w_hz;
  logic             w_pc_pend;
  logic             w_issue;
  logic             w_unused;

  // RegWriteE is part of the stage interface but no hazard decision depends on it
  assign w_unused = RegWriteE;

  // Memory stage result has priority over Writeback
  always_comb begin
    w_fwd = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (RegWriteM && (RAE[i*AW +: AW] == WA3M))
        w_fwd[2*i +: 2] = 2'b10;
      else if (RegWriteW && (RAE[i*AW +: AW] == WA3W))
        w_fwd[2*i +: 2] = 2'b01;
    end
  end

  // A pending register being written back by the multiplier this cycle no longer blocks
  always_comb begin
    w_pend_eff = '0;
    for (int unsigned r = 0; r < NREG; r++)
      w_pend_eff[r] = r_pend[r] & ~(MulDone & (MulWA == AW'(r)));
  end

  always_comb begin
    w_ldr_stall  = 1'b0;
    w_pend_stall = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (RVD[i]) begin
        if (RAD[i*AW +: AW] == WA3E) begin
          if (MemtoRegE) w_ldr_stall  = 1'b1;
          if (MulIssueE) w_pend_stall = 1'b1;
        end
        for (int unsigned r = 0; r < NREG; r++)
          if (w_pend_eff[r] && (RAD[i*AW +: AW] == AW'(r))) w_pend_stall = 1'b1;
      end
    end
  end

  assign w_struct_stall = MulD & (r_busy_cnt > CW'(1));
  assign w_hz           = w_ldr_stall | w_pend_stall | w_struct_stall;
  assign w_pc_pend      = PCSrcD | PCSrcE | PCSrcM;

  // Combinational outputs are forced quiet while reset is held
  assign StallD   = rst_n & w_hz;
  assign StallF   = rst_n & (w_hz | w_pc_pend);
  assign FlushE   = rst_n & (w_hz | BranchTakenE);
  assign FlushD   = rst_n & (w_pc_pend | PCSrcW | BranchTakenE);
  assign ForwardE = rst_n ? w_fwd : '0;
  assign MulBusy  = (r_busy_cnt != '0);

  assign w_issue    = MulIssueE & ~FlushE;
  assign StallCount = r_stall_cnt;

  // Scoreboard: a new issue wins over a completion to the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (w_issue && (WA3E == AW'(r)))
          r_pend[r] <= 1'b1;
        else if (MulDone && (MulWA == AW'(r)))
          r_pend[r] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_busy_cnt <= '0;
    else if (w_issue)
      r_busy_cnt <= CW'(MUL_LAT);
    else if (r_busy_cnt != '0)
      r_busy_cnt <= r_busy_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (StallClr)
      r_stall_cnt <= '0;
    else if (StallD && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + SCW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a rule-level reference model.
module tb_hazard_scoreboard;

  localparam int unsigned NREG    = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned NRD     = 2;
  localparam int unsigned MUL_LAT = 3;

  logic              clk;
  logic              rst_n;
  logic [NRD*AW-1:0] RAD, RAE;
  logic [NRD-1:0]    RVD;
  logic [AW-1:0]     WA3E, WA3M, WA3W, MulWA;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulD, MulIssueE, MulDone;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, StallClr;
  logic StallF, StallD, FlushD, FlushE, MulBusy;
  logic [2*NRD-1:0] ForwardE;
  logic [15:0]      StallCount;

  int n_total = 0;
  int n_bad   = 0;

  bit m_pend [NREG];
  int m_busy;
  int m_cnt;

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .RAD(RAD), .RVD(RVD), .RAE(RAE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MulD(MulD), .MulIssueE(MulIssueE), .MulDone(MulDone),
    .MulWA(MulWA), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .StallClr(StallClr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardE(ForwardE), .MulBusy(MulBusy), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    m_busy = 0;
    m_cnt  = 0;
  endtask

  function automatic int rd(input int i);
    return int'(RAD[i*AW +: AW]);
  endfunction

  // Expected combinational outputs from the current inputs and model state
  task automatic calc(output bit eF, output bit eD, output bit eFD, output bit eFE,
                      output logic [2*NRD-1:0] eFW);
    bit ldr, pst, sst, hz, pcp;
    eFW = '0;
    ldr = 0; pst = 0;
    for (int i = 0; i < NRD; i++) begin
      int a;
      a = int'(RAE[i*AW +: AW]);
      if (RegWriteM && a == int'(WA3M))      eFW[2*i +: 2] = 2'b10;
      else if (RegWriteW && a == int'(WA3W)) eFW[2*i +: 2] = 2'b01;
      if (RVD[i]) begin
        if (MemtoRegE && rd(i) == int'(WA3E)) ldr = 1;
        if (MulIssueE && rd(i) == int'(WA3E)) pst = 1;
        if (m_pend[rd(i)] && !(MulDone && int'(MulWA) == rd(i))) pst = 1;
      end
    end
    sst = MulD && (m_busy > 1);
    hz  = ldr | pst | sst;
    pcp = PCSrcD | PCSrcE | PCSrcM;
    eD  = hz;
    eF  = hz | pcp;
    eFE = hz | BranchTakenE;
    eFD = pcp | PCSrcW | BranchTakenE;
    if (!rst_n) begin
      eF = 0; eD = 0; eFD = 0; eFE = 0; eFW = '0;
    end
  endtask

  task automatic m_edge(input bit eD, input bit eFE);
    bit issue;
    issue = MulIssueE && !eFE;
    if (MulDone) m_pend[int'(MulWA)] = 1'b0;
    if (issue)   m_pend[int'(WA3E)]  = 1'b1;
    if (issue)            m_busy = MUL_LAT;
    else if (m_busy > 0)  m_busy = m_busy - 1;
    if (StallClr)                 m_cnt = 0;
    else if (eD && m_cnt < 65535) m_cnt = m_cnt + 1;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic tick(input bit chk);
    bit eF, eD, eFD, eFE;
    logic [2*NRD-1:0] eFW;
    if (!rst_n) m_reset();
    #1;
    calc(eF, eD, eFD, eFE, eFW);
    if (chk) begin
      chk_eq("StallF", StallF, eF);
      chk_eq("StallD", StallD, eD);
      chk_eq("FlushD", FlushD, eFD);
      chk_eq("FlushE", FlushE, eFE);
      chk_eq("ForwardE", ForwardE, eFW);
      chk_eq("MulBusy", MulBusy, (m_busy != 0));
      chk_eq("StallCount", StallCount, m_cnt);
    end
    @(posedge clk);
    if (rst_n) m_edge(eD, eFE);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    RAD = '0; RVD = '0; RAE = '0; WA3E = '0; WA3M = '0; WA3W = '0; MulWA = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MulD = 0;
    MulIssueE = 0; MulDone = 0; PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; StallClr = 0;
  endtask

  function automatic logic [AW-1:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(4, 7));
  endfunction

  function automatic bit chance(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NRD; i++) begin
      RAD[i*AW +: AW] = pick_reg();
      RAE[i*AW +: AW] = pick_reg();
    end
    RVD = NRD'($urandom);
    WA3E = pick_reg(); WA3M = pick_reg(); WA3W = pick_reg(); MulWA = pick_reg();
    RegWriteE = chance(50); RegWriteM = chance(50); RegWriteW = chance(50);
    MemtoRegE = chance(20); MulD = chance(25); MulIssueE = chance(25);
    MulDone = chance(25);
    PCSrcD = chance(8); PCSrcE = chance(8); PCSrcM = chance(8); PCSrcW = chance(8);
    BranchTakenE = chance(8); StallClr = chance(3);
    rst_n = !chance(1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Forwarding priority
    RAE = {AW'(0), AW'(3)}; WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
    #1 chk_eq("fwd_mem_prio", ForwardE[1:0], 2'b10);
    tick(1);
    RegWriteM = 0;
    #1 chk_eq("fwd_wb", ForwardE[1:0], 2'b01);
    tick(1);

    // Load-use on port 1, then with the port invalid
    idle_inputs();
    MemtoRegE = 1; WA3E = 4'd5; RAD = {AW'(5), AW'(0)}; RVD = 2'b10;
    #1 chk_eq("ldr_stall", {StallF, StallD, FlushE}, 3'b111);
    tick(1);
    RVD = 2'b00;
    #1 chk_eq("ldr_invalid_port", {StallF, StallD, FlushE}, 3'b000);
    tick(1);

    // Multiply to R7 blocks a reader until its completion cycle
    idle_inputs();
    MulIssueE = 1; WA3E = 4'd7;
    tick(1);
    MulIssueE = 0; RAD = {AW'(0), AW'(7)}; RVD = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 chk_eq("pend_stall", StallD, 1'b1);
      tick(1);
    end
    MulDone = 1; MulWA = 4'd7;
    #1 chk_eq("pend_done_cycle", StallD, 1'b0);
    tick(1);
    MulDone = 0;
    tick(1);

    // Back-to-back multiply waits for the unit
    idle_inputs();
    MulIssueE = 1; WA3E = 4'd2;
    tick(1);
    MulIssueE = 0; MulD = 1;
    #1 chk_eq("struct_busy3", StallD, 1'b1);
    tick(1);
    #1 chk_eq("struct_busy2", StallD, 1'b1);
    tick(1);
    #1 chk_eq("struct_busy1", {StallD, MulBusy}, 2'b01);
    tick(1);
    idle_inputs();
    MulDone = 1; MulWA = 4'd2;
    tick(1);

    // Stall counter saturation and clear
    idle_inputs();
    MemtoRegE = 1; WA3E = 4'd5; RAD = {AW'(0), AW'(5)}; RVD = 2'b01;
    for (int k = 0; k < 70000; k++) tick(k % 8192 == 0);
    #1 chk_eq("stallcnt_sat", StallCount, 16'hFFFF);
    StallClr = 1;
    tick(1);
    idle_inputs();
    #1 chk_eq("stallcnt_clr", StallCount, 16'h0000);
    tick(1);

    // Asynchronous reset in the middle of a multiply
    MulIssueE = 1; WA3E = 4'd7;
    tick(1);
    MulIssueE = 0;
    tick(1);
    RAD = {AW'(0), AW'(7)}; RVD = 2'b01; MulD = 1; PCSrcD = 1; BranchTakenE = 1;
    RegWriteM = 1; WA3M = 4'd3; RAE = {AW'(3), AW'(3)};
    #1 chk_eq("pre_reset_stall", {StallD, MulBusy}, 2'b11);
    #1 rst_n = 1'b0;
    m_reset();
    #1 chk_eq("async_reset_outs",
              {StallF, StallD, FlushD, FlushE, MulBusy, ForwardE, StallCount}, '0);
    tick(1);
    rst_n = 1'b1;
    idle_inputs();
    RAD = {AW'(0), AW'(7)}; RVD = 2'b01;
    #1 chk_eq("post_reset_no_stall", StallD, 1'b0);
    tick(1);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rand_inputs();
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
